// File: rtl/dcpu_operand_fetch_pkg.sv
// Shared definitions for the DCPU-16 operand fetch block.
// Contents: operand-field constants for the 0x18-0x1f special values,
// destination-kind encodings, operand-field classes and FSM state codes.
package dcpu_operand_fetch_pkg;

  // Special operand field values (6-bit a/b fields)
  localparam logic [5:0] VAL_POP    = 6'h18;
  localparam logic [5:0] VAL_PEEK   = 6'h19;
  localparam logic [5:0] VAL_PUSH   = 6'h1a;
  localparam logic [5:0] VAL_SP     = 6'h1b;
  localparam logic [5:0] VAL_PC     = 6'h1c;
  localparam logic [5:0] VAL_O      = 6'h1d;
  localparam logic [5:0] VAL_NW_IND = 6'h1e;
  localparam logic [5:0] VAL_NW_LIT = 6'h1f;

  // Destination descriptor handed to writeback
  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_REG  = 3'd1,
    DST_MEM  = 3'd2,
    DST_SP   = 3'd3,
    DST_PC   = 3'd4,
    DST_O    = 3'd5
  } dst_kind_e;

  // Resolution class of one operand field
  typedef enum logic [3:0] {
    CLS_REG    = 4'd0,   // 00-07 register
    CLS_IND    = 4'd1,   // 08-0f [reg]
    CLS_NW_REG = 4'd2,   // 10-17 [next+reg]
    CLS_POP    = 4'd3,   // [sp++]
    CLS_PEEK   = 4'd4,   // [sp]
    CLS_PUSH   = 4'd5,   // [--sp]
    CLS_SP     = 4'd6,
    CLS_PC     = 4'd7,
    CLS_O      = 4'd8,
    CLS_NW_IND = 4'd9,   // [next]
    CLS_NW_LIT = 4'd10,  // next (literal)
    CLS_LIT    = 4'd11   // 20-3f short literal
  } field_cls_e;

  // Fetch FSM; exported on dbg_state
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_NW  = 3'd1,
    S_A_MEM = 3'd2,
    S_B_NW  = 3'd3,
    S_B_MEM = 3'd4,
    S_EMIT  = 3'd5
  } state_e;

endpackage

// File: rtl/dcpu_operand_decode.sv
// Combinational decode of one 6-bit DCPU-16 operand field.
// Ports:
//   field_i      6-bit operand field
//   cls_o        field_cls_e class of the field
//   reg_idx_o    register index (field[2:0]), meaningful for register-based classes
//   needs_nw_o   field consumes the next instruction word
//   needs_mem_o  field performs a memory read (includes PUSH)
//   dst_kind_o   dst_kind_e the field represents when used as a destination
module dcpu_operand_decode
  import dcpu_operand_fetch_pkg::*;
(
  input  logic [5:0] field_i,
  output logic [3:0] cls_o,
  output logic [2:0] reg_idx_o,
  output logic       needs_nw_o,
  output logic       needs_mem_o,
  output logic [2:0] dst_kind_o
);

  field_cls_e cls;
  dst_kind_e  dk;

  always_comb begin
    cls = CLS_LIT;
    if (!field_i[5]) begin
      case (field_i[4:3])
        2'd0: cls = CLS_REG;
        2'd1: cls = CLS_IND;
        2'd2: cls = CLS_NW_REG;
        default: begin
          case (field_i)
            VAL_POP:    cls = CLS_POP;
            VAL_PEEK:   cls = CLS_PEEK;
            VAL_PUSH:   cls = CLS_PUSH;
            VAL_SP:     cls = CLS_SP;
            VAL_PC:     cls = CLS_PC;
            VAL_O:      cls = CLS_O;
            VAL_NW_IND: cls = CLS_NW_IND;
            default:    cls = CLS_NW_LIT;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    dk = DST_NONE;
    case (cls)
      CLS_REG:                                   dk = DST_REG;
      CLS_IND, CLS_NW_REG, CLS_POP, CLS_PEEK,
      CLS_PUSH, CLS_NW_IND:                      dk = DST_MEM;
      CLS_SP:                                    dk = DST_SP;
      CLS_PC:                                    dk = DST_PC;
      CLS_O:                                     dk = DST_O;
      default:                                   dk = DST_NONE;
    endcase
  end

  assign cls_o       = cls;
  assign reg_idx_o   = field_i[2:0];
  assign needs_nw_o  = (cls == CLS_NW_REG) || (cls == CLS_NW_IND) || (cls == CLS_NW_LIT);
  assign needs_mem_o = (cls == CLS_IND) || (cls == CLS_NW_REG) || (cls == CLS_POP) ||
                       (cls == CLS_PEEK) || (cls == CLS_PUSH) || (cls == CLS_NW_IND);
  assign dst_kind_o  = dk;

endmodule

// File: rtl/dcpu_operand_fetch.sv
// DCPU-16 operand fetch: accepts one instruction word, resolves field a then
// field b (registers, memory, SP/PC/O, next words, literals) and presents the
// resolved operation plus a destination descriptor to the ALU/writeback stage.
// PC/SP side effects are only published via pc_next/sp_next and take effect
// when the consumer sees commit.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   instr_valid/instr        instruction in; instr_ready high only in IDLE
//   pc_in, sp_in, o_in       PC (word after instr), SP, O; sampled on accept
//   rf_raddr_a/b, rf_rdata_a/b  combinational register-file read ports
//   mem_req/mem_addr         read request, held stable until mem_ack
//   mem_ack/mem_rdata        one-cycle ack with data
//   op_valid/op_ready        resolved operation handshake
//   opcode, nb_op, a, b      operation and operand values
//   dst_kind/dst_reg/dst_addr destination descriptor (field a)
//   commit                   op_valid & op_ready
//   pc_next, sp_next         PC/SP values to take on commit
//   dbg_state                current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once op_valid is raised it and all op outputs hold until
// op_ready. instr_valid is ignored outside IDLE.
module dcpu_operand_fetch
  import dcpu_operand_fetch_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] sp_in,
  input  logic [DW-1:0] o_in,
  output logic [2:0]    rf_raddr_a,
  output logic [2:0]    rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [3:0]    opcode,
  output logic [5:0]    nb_op,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [2:0]    dst_kind,
  output logic [2:0]    dst_reg,
  output logic [AW-1:0] dst_addr,
  output logic          commit,
  output logic [AW-1:0] pc_next,
  output logic [AW-1:0] sp_next,
  output logic [2:0]    dbg_state
);

  localparam logic [AW-1:0] ONE_A = AW'(1);

  state_e        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [AW-1:0] pc_q, pc_d, sp_q, sp_d, daddr_q, daddr_d;
  logic [DW-1:0] o_q, o_d, nw_q, nw_d, a_q, a_d, b_q, b_d;
  logic [2:0]    dk_q, dk_d, dreg_q, dreg_d;

  // In IDLE the live inputs are decoded so a register/literal-only
  // instruction resolves in its accept cycle.
  logic          idle;
  logic [15:0]   instr_c;
  logic [AW-1:0] pc_c, sp_c;
  logic [DW-1:0] o_c;
  logic          basic;
  logic [5:0]    field_a, field_b;

  assign idle    = (state_q == S_IDLE);
  assign instr_c = idle ? instr : instr_q;
  assign pc_c    = idle ? pc_in : pc_q;
  assign sp_c    = idle ? sp_in : sp_q;
  assign o_c     = idle ? o_in  : o_q;
  assign basic   = (instr_c[3:0] != 4'd0);
  // Non-basic instructions carry their single operand in the b position
  assign field_a = basic ? instr_c[9:4] : instr_c[15:10];
  assign field_b = instr_c[15:10];

  logic [3:0] cls_a, cls_b;
  logic       nw_a, nw_b, mem_a, mem_b;
  logic [2:0] dk_a, unused_dk_b;
  field_cls_e cls_a_e, cls_b_e;

  dcpu_operand_decode u_dec_a (
    .field_i     (field_a),
    .cls_o       (cls_a),
    .reg_idx_o   (rf_raddr_a),
    .needs_nw_o  (nw_a),
    .needs_mem_o (mem_a),
    .dst_kind_o  (dk_a)
  );

  dcpu_operand_decode u_dec_b (
    .field_i     (field_b),
    .cls_o       (cls_b),
    .reg_idx_o   (rf_raddr_b),
    .needs_nw_o  (nw_b),
    .needs_mem_o (mem_b),
    .dst_kind_o  (unused_dk_b)
  );

  assign cls_a_e = field_cls_e'(cls_a);
  assign cls_b_e = field_cls_e'(cls_b);

  // Read address of a memory-mode field; PUSH reads the pre-decremented SP.
  function automatic logic [AW-1:0] field_addr(input field_cls_e cls, input logic [DW-1:0] nw,
                                               input logic [DW-1:0] rd, input logic [AW-1:0] sp);
    logic [AW-1:0] r;
    case (cls)
      CLS_IND:    r = AW'(rd);
      CLS_NW_REG: r = AW'(nw + rd);
      CLS_PUSH:   r = sp - ONE_A;
      CLS_NW_IND: r = AW'(nw);
      default:    r = sp;  // POP, PEEK
    endcase
    return r;
  endfunction

  function automatic logic [AW-1:0] sp_adjust(input field_cls_e cls, input logic [AW-1:0] sp);
    logic [AW-1:0] r;
    case (cls)
      CLS_POP:  r = sp + ONE_A;
      CLS_PUSH: r = sp - ONE_A;
      default:  r = sp;
    endcase
    return r;
  endfunction

  // Value of a field that needs no memory read and no next word
  function automatic logic [DW-1:0] field_val(input field_cls_e cls, input logic [DW-1:0] rd,
                                              input logic [AW-1:0] sp, input logic [AW-1:0] pc,
                                              input logic [DW-1:0] o, input logic [4:0] lit);
    logic [DW-1:0] r;
    case (cls)
      CLS_REG: r = rd;
      CLS_SP:  r = DW'(sp);
      CLS_PC:  r = DW'(pc);
      CLS_O:   r = o;
      default: r = DW'(lit);
    endcase
    return r;
  endfunction

  logic          go_b;
  logic [AW-1:0] sp_v, pc_v;
  logic          mem_req_c;
  logic [AW-1:0] mem_addr_c;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    o_d        = o_q;
    nw_d       = nw_q;
    a_d        = a_q;
    b_d        = b_q;
    dk_d       = dk_q;
    dreg_d     = dreg_q;
    daddr_d    = daddr_q;
    mem_req_c  = 1'b0;
    mem_addr_c = '0;
    go_b       = 1'b0;
    sp_v       = sp_c;
    pc_v       = pc_c;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          pc_d    = pc_in;
          sp_d    = sp_in;
          o_d     = o_in;
          nw_d    = '0;
          a_d     = '0;
          b_d     = '0;
          daddr_d = '0;
          dk_d    = basic ? dk_a : DST_NONE;
          dreg_d  = (basic && dk_a == DST_REG) ? rf_raddr_a : 3'd0;
          if (nw_a)       state_d = S_A_NW;
          else if (mem_a) state_d = S_A_MEM;
          else begin
            a_d  = field_val(cls_a_e, rf_rdata_a, sp_c, pc_c, o_c, field_a[4:0]);
            go_b = 1'b1;
          end
        end
      end
      S_A_NW: begin
        mem_req_c  = 1'b1;
        mem_addr_c = pc_q;
        if (mem_ack) begin
          pc_v = pc_q + ONE_A;
          pc_d = pc_v;
          nw_d = mem_rdata;
          if (mem_a) state_d = S_A_MEM;
          else begin
            a_d  = mem_rdata;  // next-word literal
            go_b = 1'b1;
          end
        end
      end
      S_A_MEM: begin
        mem_req_c  = 1'b1;
        mem_addr_c = field_addr(cls_a_e, nw_q, rf_rdata_a, sp_q);
        if (mem_ack) begin
          a_d = mem_rdata;
          if (dk_q == DST_MEM) daddr_d = mem_addr_c;
          sp_v = sp_adjust(cls_a_e, sp_q);
          sp_d = sp_v;
          go_b = 1'b1;
        end
      end
      S_B_NW: begin
        mem_req_c  = 1'b1;
        mem_addr_c = pc_q;
        if (mem_ack) begin
          pc_d = pc_q + ONE_A;
          nw_d = mem_rdata;
          if (mem_b) state_d = S_B_MEM;
          else begin
            b_d     = mem_rdata;
            state_d = S_EMIT;
          end
        end
      end
      S_B_MEM: begin
        mem_req_c  = 1'b1;
        mem_addr_c = field_addr(cls_b_e, nw_q, rf_rdata_b, sp_q);
        if (mem_ack) begin
          b_d     = mem_rdata;
          sp_d    = sp_adjust(cls_b_e, sp_q);
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (op_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Field a is finished this cycle; start b using SP/PC as a left them.
    if (go_b) begin
      if (!basic) begin
        b_d     = '0;
        state_d = S_EMIT;
      end else if (nw_b) begin
        state_d = S_B_NW;
      end else if (mem_b) begin
        state_d = S_B_MEM;
      end else begin
        b_d     = field_val(cls_b_e, rf_rdata_b, sp_v, pc_v, o_c, field_b[4:0]);
        state_d = S_EMIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      sp_q    <= '0;
      o_q     <= '0;
      nw_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dk_q    <= DST_NONE;
      dreg_q  <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      o_q     <= o_d;
      nw_q    <= nw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dk_q    <= dk_d;
      dreg_q  <= dreg_d;
      daddr_q <= daddr_d;
    end
  end

  assign instr_ready = idle;
  assign mem_req     = mem_req_c;
  assign mem_addr    = mem_addr_c;
  assign op_valid    = (state_q == S_EMIT);
  assign commit      = op_valid & op_ready;
  assign opcode      = instr_q[3:0];
  assign nb_op       = (instr_q[3:0] == 4'd0) ? instr_q[9:4] : 6'd0;
  assign a           = a_q;
  assign b           = b_q;
  assign dst_kind    = dk_q;
  assign dst_reg     = dreg_q;
  assign dst_addr    = daddr_q;
  assign pc_next     = pc_q;
  assign sp_next     = sp_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dcpu_operand_fetch.sv
// Bench for dcpu_operand_fetch: table of directed instruction vectors with
// hand-computed results, a memory responder that checks read addresses
// against an expected queue, and hand-written backpressure/reset sequences.
module tb_dcpu_operand_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        instr_valid, instr_ready;
  logic [15:0] instr, pc_in, sp_in, o_in;
  logic [2:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, mem_rdata;
  logic        op_valid, op_ready, commit;
  logic [3:0]  opcode;
  logic [5:0]  nb_op;
  logic [15:0] a, b, dst_addr, pc_next, sp_next;
  logic [2:0]  dst_kind, dst_reg, dbg_state;

  dcpu_operand_fetch #(.DW(16), .AW(16)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .pc_in(pc_in), .sp_in(sp_in), .o_in(o_in),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .nb_op(nb_op), .a(a), .b(b),
    .dst_kind(dst_kind), .dst_reg(dst_reg), .dst_addr(dst_addr),
    .commit(commit), .pc_next(pc_next), .sp_next(sp_next), .dbg_state(dbg_state)
  );

  // ---------------- models ----------------
  logic [15:0] rf [8];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  logic [15:0] mem_m [logic [15:0]];
  function automatic logic [15:0] mem_rd(input logic [15:0] addr);
    return mem_m.exists(addr) ? mem_m[addr] : 16'hDEAD;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0, n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$];   // expected memory read addresses, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic        mem_hold = 1'b0, ack_r = 1'b0, late_ack = 1'b0;
  logic [15:0] rd_r = '0, late_data = '0;
  assign mem_ack   = ack_r | late_ack;
  assign mem_rdata = late_ack ? late_data : rd_r;

  // A request seen at a falling edge is always a fresh one, so acking every
  // such cycle gives exactly one ack per read.
  always @(negedge clk) begin
    ack_r = 1'b0;
    if (mem_req && !mem_hold) begin
      ack_r = 1'b1;
      rd_r  = mem_rd(mem_addr);
      if (exp_q.size() == 0) check("unexpected_read", {16'd0, mem_addr}, 32'hFFFF_FFFF);
      else check("read_addr", {16'd0, mem_addr}, {16'd0, exp_q.pop_front()});
    end
  end

  int commit_cnt = 0;
  always @(posedge clk) if (commit) commit_cnt++;

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] instr, pc, sp, o;
    int          n_rd;
    logic [15:0] rd0, rd1, rd2;
    logic [3:0]  opc;
    logic [5:0]  nb;
    logic [15:0] a, b;
    logic [2:0]  dk, dreg;
    logic [15:0] daddr, pcn, spn;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] i_instr, i_pc, i_sp, i_o, input int i_n,
                              input logic [15:0] i_r0, i_r1, i_r2, input logic [3:0] i_opc,
                              input logic [5:0] i_nb, input logic [15:0] i_a, i_b,
                              input logic [2:0] i_dk, i_dreg, input logic [15:0] i_da, i_pcn, i_spn);
    vec_t v;
    v.instr = i_instr; v.pc = i_pc; v.sp = i_sp; v.o = i_o; v.n_rd = i_n;
    v.rd0 = i_r0; v.rd1 = i_r1; v.rd2 = i_r2; v.opc = i_opc; v.nb = i_nb;
    v.a = i_a; v.b = i_b; v.dk = i_dk; v.dreg = i_dreg; v.daddr = i_da;
    v.pcn = i_pcn; v.spn = i_spn;
    return v;
  endfunction

  localparam int NV = 13;
  vec_t vecs [NV];

  // dst kinds: 0 NONE, 1 REG, 2 MEM, 3 SP, 4 PC, 5 O
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    n_vec++;
    @(negedge clk);
    check({tag, ".instr_ready"}, {31'd0, instr_ready}, 32'd1);
    instr = v.instr; pc_in = v.pc; sp_in = v.sp; o_in = v.o; instr_valid = 1'b1;
    if (v.n_rd > 0) exp_q.push_back(v.rd0);
    if (v.n_rd > 1) exp_q.push_back(v.rd1);
    if (v.n_rd > 2) exp_q.push_back(v.rd2);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!op_valid && lat < 40);
    check({tag, ".latency"},  lat, 1 + v.n_rd);
    check({tag, ".op_valid"}, {31'd0, op_valid}, 32'd1);
    check({tag, ".opcode"},   {28'd0, opcode}, {28'd0, v.opc});
    check({tag, ".nb_op"},    {26'd0, nb_op}, {26'd0, v.nb});
    check({tag, ".a"},        {16'd0, a}, {16'd0, v.a});
    check({tag, ".b"},        {16'd0, b}, {16'd0, v.b});
    check({tag, ".dst_kind"}, {29'd0, dst_kind}, {29'd0, v.dk});
    check({tag, ".dst_reg"},  {29'd0, dst_reg}, {29'd0, v.dreg});
    check({tag, ".dst_addr"}, {16'd0, dst_addr}, {16'd0, v.daddr});
    check({tag, ".pc_next"},  {16'd0, pc_next}, {16'd0, v.pcn});
    check({tag, ".sp_next"},  {16'd0, sp_next}, {16'd0, v.spn});
    check({tag, ".commit"},   {31'd0, commit}, {31'd0, op_ready});
    check({tag, ".reads_left"}, exp_q.size(), 0);
    exp_q.delete();
    if (op_ready) begin
      @(negedge clk);
      check({tag, ".idle_after"}, {30'd0, op_valid, instr_ready}, 32'd1);
    end
  endtask

  // ---------------- main test ----------------
  initial begin : main
    int c0;
    instr_valid = 1'b0; instr = '0; pc_in = '0; sp_in = '0; o_in = '0; op_ready = 1'b1;
    rf[0] = 16'h1234; rf[1] = 16'h2000; rf[2] = 16'hFFF8; rf[3] = 16'h3333;
    for (int i = 4; i < 8; i++) rf[i] = 16'h0400 + 16'(i);
    mem_m[16'h0010] = 16'h1000; mem_m[16'h0011] = 16'h0020; mem_m[16'h1000] = 16'h5555;
    mem_m[16'hFFF0] = 16'h0007; mem_m[16'hFFFF] = 16'hABCD; mem_m[16'h0300] = 16'h0200;
    mem_m[16'h2000] = 16'h0BEE; mem_m[16'h0400] = 16'h0010; mem_m[16'h0008] = 16'h4242;
    mem_m[16'h3000] = 16'h0099; mem_m[16'h4000] = 16'h1111; mem_m[16'h5000] = 16'h2222;

    //               instr     pc        sp        o         n rd0       rd1       rd2      opc nb     a         b         dk dreg daddr    pcn       spn
    vecs[0]  = mk(16'hC001, 16'h0050, 16'h8000, 16'h0000, 0, 16'h0,    16'h0,    16'h0,    1, 6'h0, 16'h1234, 16'h0010, 1, 0, 16'h0000, 16'h0050, 16'h8000); // SET A,0x10
    vecs[1]  = mk(16'h7DE1, 16'h0010, 16'h8000, 16'h0000, 3, 16'h0010, 16'h1000, 16'h0011, 1, 6'h0, 16'h5555, 16'h0020, 2, 0, 16'h1000, 16'h0012, 16'h8000); // SET [0x1000],0x20
    vecs[2]  = mk(16'h6002, 16'h0060, 16'hFFF0, 16'h0000, 1, 16'hFFF0, 16'h0,    16'h0,    2, 6'h0, 16'h1234, 16'h0007, 1, 0, 16'h0000, 16'h0060, 16'hFFF1); // ADD A,POP
    vecs[3]  = mk(16'h95A1, 16'h0070, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h0,    16'h0,    1, 6'h0, 16'hABCD, 16'h0005, 2, 0, 16'hFFFF, 16'h0070, 16'hFFFF); // SET PUSH,5 (wrap)
    vecs[4]  = mk(16'h7C10, 16'h0300, 16'h8000, 16'h0000, 1, 16'h0300, 16'h0,    16'h0,    0, 6'h1, 16'h0200, 16'h0000, 0, 0, 16'h0000, 16'h0301, 16'h8000); // JSR next
    vecs[5]  = mk(16'h2431, 16'h0080, 16'h8000, 16'h0000, 1, 16'h2000, 16'h0,    16'h0,    1, 6'h0, 16'h3333, 16'h0BEE, 1, 3, 16'h0000, 16'h0080, 16'h8000); // SET X,[B]
    vecs[6]  = mk(16'h7522, 16'h0400, 16'h8000, 16'h0077, 2, 16'h0400, 16'h0008, 16'h0,    2, 6'h0, 16'h4242, 16'h0077, 2, 0, 16'h0008, 16'h0401, 16'h8000); // ADD [next+C],O (wrap)
    vecs[7]  = mk(16'h65B3, 16'h0090, 16'h3000, 16'h0000, 1, 16'h3000, 16'h0,    16'h0,    3, 6'h0, 16'h3000, 16'h0099, 3, 0, 16'h0000, 16'h0090, 16'h3000); // SUB SP,PEEK
    vecs[8]  = mk(16'h61C1, 16'h0500, 16'h4000, 16'h0000, 1, 16'h4000, 16'h0,    16'h0,    1, 6'h0, 16'h0500, 16'h1111, 4, 0, 16'h0000, 16'h0500, 16'h4001); // SET PC,POP
    vecs[9]  = mk(16'h6D81, 16'h00A0, 16'h5000, 16'h0000, 1, 16'h5000, 16'h0,    16'h0,    1, 6'h0, 16'h2222, 16'h5001, 2, 0, 16'h5000, 16'h00A0, 16'h5001); // SET POP,SP
    vecs[10] = mk(16'h0010, 16'h00B0, 16'h8000, 16'h0000, 0, 16'h0,    16'h0,    16'h0,    0, 6'h1, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h00B0, 16'h8000); // JSR A
    vecs[11] = mk(16'hFC1B, 16'h00C0, 16'h8000, 16'h0000, 0, 16'h0,    16'h0,    16'h0,    11, 6'h0, 16'h2000, 16'h001F, 1, 1, 16'h0000, 16'h00C0, 16'h8000); // XOR B,31
    vecs[12] = mk(16'h81D1, 16'h00D0, 16'h8000, 16'h00AB, 0, 16'h0,    16'h0,    16'h0,    1, 6'h0, 16'h00AB, 16'h0000, 5, 0, 16'h0000, 16'h00D0, 16'h8000); // SET O,0

    // reset state
    repeat (2) @(negedge clk);
    check("rst.instr_ready", {31'd0, instr_ready}, 32'd1);
    check("rst.mem_req",     {31'd0, mem_req}, 32'd0);
    check("rst.op_valid",    {31'd0, op_valid}, 32'd0);
    check("rst.commit",      {31'd0, commit}, 32'd0);
    check("rst.data",        {a, pc_next}, 32'd0);
    check("rst.state",       {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // backpressure: hold op_ready low 3 cycles with a competing instr offered
    n_vec++;
    op_ready = 1'b0;
    run_vec(vecs[0], "bp");
    c0 = commit_cnt;
    instr_valid = 1'b1; instr = 16'h7DE1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d", k), {a, b}, {16'h1234, 16'h0010});
      check($sformatf("bp.flags%0d", k), {29'd0, op_valid, instr_ready, commit}, 32'b100);
      check($sformatf("bp.pc%0d", k), {16'd0, pc_next}, 32'h0050);
    end
    op_ready = 1'b1; instr_valid = 1'b0;
    #1 check("bp.commit", {31'd0, commit}, 32'd1);
    @(negedge clk);
    check("bp.commit_cnt", commit_cnt - c0, 1);
    check("bp.idle", {30'd0, op_valid, instr_ready}, 32'd1);

    // reset while a read is outstanding
    n_vec++;
    mem_hold = 1'b1;
    @(negedge clk);
    instr = 16'h7DE1; pc_in = 16'h0010; sp_in = 16'h8000; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("rr.req_pending", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0010});
    #1 rst = 1'b1;
    #1 check("rr.async_drop", {30'd0, mem_req, op_valid}, 32'd0);
    check("rr.ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    late_data = 16'h7777; late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    check("rr.late_ack", {29'd0, instr_ready, mem_req, op_valid}, 32'b100);
    check("rr.state", {29'd0, dbg_state}, 32'd0);
    mem_hold = 1'b0;
    run_vec(vecs[1], "rr.v1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
